mem_channel_scheduler: RTL
==========================

// Module: mem_channel_scheduler
// PURPOSE
//  Shares NUM_CHANNELS independent memory channels among NUM_CONSUMERS LSU/fetcher requesters.
//  Round-robin claims a pending consumer per idle channel, then runs one read or write per claim.
//  Returns the result to the consumer over a four-phase valid/ready handshake.
//  Sits between the per-core LSUs and the external data-memory ports.
// PARAMETERS
//  ADDR_BITS      8   memory address width
//  DATA_BITS      16  memory data width
//  NUM_CONSUMERS  4   requesters; must be >= 2
//  NUM_CHANNELS   2   memory channels; must be 1..NUM_CONSUMERS
// PORTS (consumer/channel buses packed, index i occupies slice [i*W +: W])
//  clk                     in   1               clock, rising edge
//  reset                   in   1               asynchronous, active-high
//  consumer_read_valid     in   NUM_CONSUMERS   read request, held until matching ready
//  consumer_read_address   in   NUM_CONSUMERS*ADDR_BITS
//  consumer_read_ready     out  NUM_CONSUMERS   read data valid; held until valid drops
//  consumer_read_data      out  NUM_CONSUMERS*DATA_BITS
//  consumer_write_valid    in   NUM_CONSUMERS   write request, held until matching ready
//  consumer_write_address  in   NUM_CONSUMERS*ADDR_BITS
//  consumer_write_data     in   NUM_CONSUMERS*DATA_BITS
//  consumer_write_ready    out  NUM_CONSUMERS   write done; held until valid drops
//  mem_read_valid          out  NUM_CHANNELS
//  mem_read_address        out  NUM_CHANNELS*ADDR_BITS
//  mem_read_ready          in   NUM_CHANNELS    one-cycle response, data valid same cycle
//  mem_read_data           in   NUM_CHANNELS*DATA_BITS
//  mem_write_valid         out  NUM_CHANNELS
//  mem_write_address       out  NUM_CHANNELS*ADDR_BITS
//  mem_write_data          out  NUM_CHANNELS*DATA_BITS
//  mem_write_ready         in   NUM_CHANNELS    one-cycle write acknowledge
//  channel_busy            out  NUM_CHANNELS    channel state != IDLE
// BEHAVIOUR
//  - Interface: one clock (clk); reset is asynchronous and active-high.
//  - Reset clears immediately (mid-transaction too): all outputs 0, every channel IDLE, rr_ptr 0, no ownership.
//  - All outputs are registered. No combinational path from input to output.
//  - Pending consumer c: (read_valid[c]|write_valid[c]) and c is not owned by any channel.
//  - Claim, each cycle: IDLE channels are served in ascending index order.
//    Each takes the first pending consumer scanning c = rr_ptr, rr_ptr+1, ... (mod NUM_CONSUMERS).
//    No consumer is claimed twice in one cycle. rr_ptr <= (last consumer claimed this cycle)+1 mod N.
//    rr_ptr is unchanged if nothing is claimed.
//  - On claim, the channel latches the consumer id, address and write data.
//    If read_valid and write_valid are both high, the read is served; the write stays pending.
//  - Channel FSM:
//    IDLE -> READ_WAIT | WRITE_WAIT on claim; mem_*_valid goes high the next cycle (one-cycle issue latency).
//    READ_WAIT: mem_read_valid=1 until the mem_read_ready cycle.
//      On that edge: valid<=0, consumer_read_data<=mem_read_data, consumer_read_ready<=1, go RELAY.
//    WRITE_WAIT: same, with mem_write_* and consumer_write_ready.
//    RELAY: ready stays high while the consumer's valid is high.
//      The first cycle valid is sampled low: ready<=0, release ownership, go IDLE.
//      The channel may claim again in that same cycle's claim phase only from the next cycle on.
//  - Latency: consumer valid in cycle 0 (channel idle) -> mem valid in cycle 1.
//    mem ready in cycle k -> consumer ready in cycle k+1.
//  - Consumer drops valid during *_WAIT (protocol violation): the memory access still completes.
//    On completion the channel goes straight to IDLE without asserting ready.
//  - consumer_read_data[c] holds its last value until overwritten by the next read for c.
//  - The mem_*_ready of a channel not in the matching WAIT state is ignored.
// STRUCTURE
//  - Package mem_sched_pkg: channel state localparams IDLE=2'd0, READ_WAIT=2'd1, WRITE_WAIT=2'd2, RELAY=2'd3.
//    Also contains function next_rr(ptr,n).
//  - Sub-module mem_sched_channel: one per channel (generate). Holds the FSM, latched request and mem_* outputs.
//    It exports done/owner/ready-pulse signals.
//  - Top level holds rr_ptr, the owned[] vector, the claim loop and the consumer ready/data registers.
// TESTING
//  1 Reset: assert reset mid READ_WAIT -> all mem_*_valid and consumer_*_ready 0 in the same cycle; channel_busy=0.
//  2 Single read: c2 reads addr 0x3C; mem ready in cycle 3 with data 0xBEEF.
//    Expect mem_read_valid[0] in cycles 1-3, consumer_read_data[2]=0xBEEF and ready in cycle 4, release after c2 drops valid.
//  3 Fairness: all 4 consumers read continuously, 1 channel, mem ready 1 cycle after valid -> grant order 0,1,2,3,0.
//  4 Parallel: c0 writes 0x1234 to 0x10 and c3 reads 0x20 in cycle 0, 2 channels.
//    Expect ch0 takes c0 and ch1 takes c3, both mem valids in cycle 1; rr_ptr=0 afterwards.
//  5 Read+write same consumer: c1 asserts both -> read served first; write claimed after ready/valid release.
//  6 Abort: c0 drops read_valid during READ_WAIT -> access completes, consumer_read_ready[0] never rises, channel IDLE.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: channel states and round-robin helper shared by the scheduler
package mem_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, READ_WAIT = 2'd1, WRITE_WAIT = 2'd2, RELAY = 2'd3} ch_state_e;
  function automatic int next_rr(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/mem_sched_channel.sv
// mem_sched_channel: one memory channel FSM holding the claimed request and registered mem_* outputs
module mem_sched_channel import mem_sched_pkg::*; #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int NUM_CONSUMERS = 4,
  localparam int CW = $clog2(NUM_CONSUMERS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               claim,
  input  logic [CW-1:0]                      claim_id,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  input  logic                               mem_read_ready,
  input  logic                               mem_write_ready,
  output logic                               idle,
  output logic [CW-1:0]                      owner,
  output logic                               is_read,
  output logic                               rd_set,
  output logic                               wr_set,
  output logic                               rel,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data
);
  ch_state_e state_q, state_d;
  logic [CW-1:0] owner_q, owner_d;
  logic is_read_q, is_read_d, rv_q, rv_d, wv_q, wv_d, cur_valid, done;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  always_comb begin
    cur_valid = is_read_q ? consumer_read_valid[owner_q] : consumer_write_valid[owner_q];
    done = (state_q == READ_WAIT && mem_read_ready) || (state_q == WRITE_WAIT && mem_write_ready);
    rd_set = done && is_read_q && cur_valid;
    wr_set = done && !is_read_q && cur_valid;
    rel = state_q == RELAY && !cur_valid;
    state_d = state_q;
    owner_d = owner_q;
    is_read_d = is_read_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && claim) begin
      owner_d = claim_id;
      is_read_d = consumer_read_valid[claim_id];
      addr_d = is_read_d ? consumer_read_address[int'(claim_id)*ADDR_BITS +: ADDR_BITS]
                         : consumer_write_address[int'(claim_id)*ADDR_BITS +: ADDR_BITS];
      wdata_d = consumer_write_data[int'(claim_id)*DATA_BITS +: DATA_BITS];
      state_d = is_read_d ? READ_WAIT : WRITE_WAIT;
    end
    // an aborted request completes on memory but skips the relay handshake
    if (done) state_d = cur_valid ? RELAY : IDLE;
    if (rel) state_d = IDLE;
    rv_d = state_d == READ_WAIT;
    wv_d = state_d == WRITE_WAIT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      is_read_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rv_q <= 1'b0;
      wv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      is_read_q <= is_read_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rv_q <= rv_d;
      wv_q <= wv_d;
    end
  end
  assign idle = state_q == IDLE;
  assign owner = owner_q;
  assign is_read = is_read_q;
  assign mem_read_valid = rv_q;
  assign mem_write_valid = wv_q;
  assign mem_read_address = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data = wdata_q;
endmodule

// File: rtl/mem_channel_scheduler.sv
// mem_channel_scheduler: round-robin sharing of memory channels among LSU/fetcher consumers
module mem_channel_scheduler import mem_sched_pkg::*; #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS = 2,
  localparam int CW = $clog2(NUM_CONSUMERS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready,
  output logic [NUM_CHANNELS-1:0]            channel_busy
);
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_CHANNELS-1:0] idle, is_read, rd_set, wr_set, rel, claim;
  logic [CW-1:0] owner [NUM_CHANNELS];
  logic [CW-1:0] claim_id [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] owned, pending, taken;
  logic [NUM_CONSUMERS-1:0] rd_ready_q, rd_ready_d, wr_ready_q, wr_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic any;
  int last;
  always_comb begin
    int c;
    owned = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) if (!idle[ch]) owned[owner[ch]] = 1'b1;
    pending = (consumer_read_valid | consumer_write_valid) & ~owned;
    taken = '0;
    claim = '0;
    any = 1'b0;
    last = 0;
    // idle channels pick in ascending order, each scanning from rr_ptr and skipping earlier picks
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      claim_id[ch] = '0;
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
        c = int'(rr_ptr_q) + k;
        c = c >= NUM_CONSUMERS ? c - NUM_CONSUMERS : c;
        if (idle[ch] && !claim[ch] && pending[c] && !taken[c]) begin
          claim[ch] = 1'b1;
          claim_id[ch] = CW'(c);
          taken[c] = 1'b1;
          any = 1'b1;
          last = c;
        end
      end
    end
    rr_ptr_d = any ? CW'(next_rr(last, NUM_CONSUMERS)) : rr_ptr_q;
  end
  always_comb begin
    rd_ready_d = rd_ready_q;
    wr_ready_d = wr_ready_q;
    rd_data_d = rd_data_q;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (rd_set[ch]) begin
        rd_ready_d[owner[ch]] = 1'b1;
        rd_data_d[int'(owner[ch])*DATA_BITS +: DATA_BITS] = mem_read_data[ch*DATA_BITS +: DATA_BITS];
      end
      if (wr_set[ch]) wr_ready_d[owner[ch]] = 1'b1;
      if (rel[ch] && is_read[ch]) rd_ready_d[owner[ch]] = 1'b0;
      if (rel[ch] && !is_read[ch]) wr_ready_d[owner[ch]] = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rd_data_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rd_data_q <= rd_data_d;
    end
  end
  assign consumer_read_ready = rd_ready_q;
  assign consumer_write_ready = wr_ready_q;
  assign consumer_read_data = rd_data_q;
  assign channel_busy = ~idle;
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    mem_sched_channel #(
      .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .NUM_CONSUMERS(NUM_CONSUMERS)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .claim(claim[i]),
      .claim_id(claim_id[i]),
      .consumer_read_valid(consumer_read_valid),
      .consumer_read_address(consumer_read_address),
      .consumer_write_valid(consumer_write_valid),
      .consumer_write_address(consumer_write_address),
      .consumer_write_data(consumer_write_data),
      .mem_read_ready(mem_read_ready[i]),
      .mem_write_ready(mem_write_ready[i]),
      .idle(idle[i]),
      .owner(owner[i]),
      .is_read(is_read[i]),
      .rd_set(rd_set[i]),
      .wr_set(wr_set[i]),
      .rel(rel[i]),
      .mem_read_valid(mem_read_valid[i]),
      .mem_read_address(mem_read_address[i*ADDR_BITS +: ADDR_BITS]),
      .mem_write_valid(mem_write_valid[i]),
      .mem_write_address(mem_write_address[i*ADDR_BITS +: ADDR_BITS]),
      .mem_write_data(mem_write_data[i*DATA_BITS +: DATA_BITS])
    );
  end
endmodule
